// File: rtl/al_spi_memory_slave_if.sv
// al_spi_memory_slave_if: split write / read-address / read-data memory handshake.
interface al_spi_memory_slave_if;
  logic [5:0]  m_mem_waddr;
  logic [31:0] m_mem_wdata;
  logic        m_mem_wvalid;
  logic        m_mem_wready;
  logic [5:0]  m_mem_araddr;
  logic        m_mem_arvalid;
  logic        m_mem_arready;
  logic [31:0] m_mem_rdata;
  logic        m_mem_rvalid;
  logic        m_mem_rready;
  modport master (
    output m_mem_waddr, m_mem_wdata, m_mem_wvalid, m_mem_araddr, m_mem_arvalid, m_mem_rready,
    input  m_mem_wready, m_mem_arready, m_mem_rdata, m_mem_rvalid
  );
  modport slave (
    input  m_mem_waddr, m_mem_wdata, m_mem_wvalid, m_mem_araddr, m_mem_arvalid, m_mem_rready,
    output m_mem_wready, m_mem_arready, m_mem_rdata, m_mem_rvalid
  );
endinterface

// File: rtl/al_spi_memory_slave.sv
// al_spi_memory_slave: oversampled SPI mode-0 responder bridging to a 64x32 memory handshake.
// Define AL_SPI_SLAVE_STATUS_EN to enable the 0x05 status-byte command.
module al_spi_memory_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int READ_DUMMY  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sclk,
  input  logic spi_csn,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  al_spi_memory_slave_if.master mem,
  output logic err_overrun,
  output logic err_underrun
);
`ifdef AL_SPI_SLAVE_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif
  localparam int CW = $clog2(READ_DUMMY + 32);
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_RD_DUMMY, ST_WR, ST_RD, ST_IGNORE, ST_STATUS} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sclk_sy, r_csn_sy, r_mosi_sy;
  logic r_sclk_d, r_rd, r_wvalid, r_arvalid, r_rwait, r_discard, r_want_ar, r_stat_done;
  logic w_sclk, w_csn, w_mosi, w_rise, w_fall, w_last, w_load, w_sload, w_take, w_wr_done, w_rdone, w_out, w_issue;
  logic [CW-1:0] r_cnt, w_lim;
  logic [31:0] r_sin, r_sout, r_wdata, w_word;
  logic [7:0] w_byte;
  logic [5:0] r_addr, r_waddr, r_araddr;
  assign w_sclk = r_sclk_sy[SYNC_STAGES-1];
  assign w_csn = r_csn_sy[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sy[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;
  assign w_word = {r_sin[30:0], w_mosi};
  assign w_byte = w_word[7:0];
  assign w_lim = (r_state == ST_RD_DUMMY) ? CW'(READ_DUMMY - 1) :
                 (r_state == ST_WR || r_state == ST_RD) ? CW'(31) : CW'(7);
  assign w_last = w_rise & (r_cnt == w_lim);
  assign w_wr_done = (r_state == ST_WR) & w_last;
  // Word/byte start is the sclk fall after the last bit, so MISO is valid before the next rise
  assign w_load = (r_state == ST_RD) & w_fall & (r_cnt == '0) & ~w_csn;
  assign w_sload = (r_state == ST_STATUS) & w_fall & (r_cnt == '0) & ~w_csn;
  assign w_take = w_load & mem.m_mem_rvalid & ~r_discard;
  assign w_rdone = mem.m_mem_rvalid & (r_discard | w_load);
  assign w_out = r_arvalid | r_rwait;
  assign w_issue = r_want_ar & ~w_out & ~w_csn;
  assign mem.m_mem_rready = w_rdone;
  assign mem.m_mem_waddr = r_waddr;
  assign mem.m_mem_wdata = r_wdata;
  assign mem.m_mem_wvalid = r_wvalid;
  assign mem.m_mem_araddr = r_araddr;
  assign mem.m_mem_arvalid = r_arvalid;
  assign spi_miso = (r_state == ST_RD || r_state == ST_STATUS) ? r_sout[31] : 1'b1;
  assign spi_miso_oe = ~w_csn;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = ST_CMD;
      ST_CMD: if (w_last) w_next = (w_byte == 8'h02 || w_byte == 8'h03) ? ST_ADDR :
                                   (STAT_EN && w_byte == 8'h05) ? ST_STATUS : ST_IGNORE;
      ST_ADDR: if (w_last) w_next = r_rd ? ST_RD_DUMMY : ST_WR;
      ST_RD_DUMMY: if (w_last) w_next = ST_RD;
      default: w_next = r_state;
    endcase
    if (w_csn) w_next = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sy <= '0;
      r_csn_sy <= '1;
      r_mosi_sy <= '0;
      r_sclk_d <= 1'b0;
      r_cnt <= '0;
      r_sin <= '0;
      r_sout <= '0;
      r_rd <= 1'b0;
      r_addr <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wvalid <= 1'b0;
      r_araddr <= '0;
      r_arvalid <= 1'b0;
      r_rwait <= 1'b0;
      r_discard <= 1'b0;
      r_want_ar <= 1'b0;
      r_stat_done <= 1'b0;
      err_overrun <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      r_sclk_sy <= {r_sclk_sy[SYNC_STAGES-2:0], spi_sclk};
      r_csn_sy <= {r_csn_sy[SYNC_STAGES-2:0], spi_csn};
      r_mosi_sy <= {r_mosi_sy[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d <= w_sclk;
      if (w_rise) begin
        r_sin <= w_word;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (r_state == ST_CMD && w_last) r_rd <= (w_byte == 8'h03);
      if (r_state == ST_ADDR && w_last) begin
        r_addr <= w_byte[7:2];
        r_want_ar <= r_rd;
      end
      if (w_wr_done) begin
        if (!r_wvalid || mem.m_mem_wready) begin
          r_wvalid <= 1'b1;
          r_waddr <= r_addr;
          r_wdata <= w_word;
        end else err_overrun <= 1'b1;
        r_addr <= r_addr + 6'd1;
      end else if (r_wvalid && mem.m_mem_wready) r_wvalid <= 1'b0;
      if (w_issue) begin
        r_arvalid <= 1'b1;
        r_araddr <= r_addr;
        r_addr <= r_addr + 6'd1;
        r_want_ar <= 1'b0;
      end else if (r_arvalid && mem.m_mem_arready) r_arvalid <= 1'b0;
      r_rwait <= (r_rwait & ~w_rdone) | (r_arvalid & mem.m_mem_arready);
      // A read still in flight after an abort or an underrun is drained and thrown away
      r_discard <= ~w_rdone & (r_discard | (w_out & (w_csn | (w_load & ~w_take))));
      if (w_load) begin
        r_sout <= w_take ? mem.m_mem_rdata : '1;
        err_underrun <= err_underrun | ~w_take;
        r_want_ar <= 1'b1;
      end else if (w_sload) r_sout <= {6'b0, err_overrun, err_underrun, 24'hFFFFFF};
      else if (w_fall) r_sout <= {r_sout[30:0], 1'b1};
      if (r_state == ST_STATUS && w_last) r_stat_done <= 1'b1;
      if (w_csn) begin
        r_cnt <= '0;
        r_addr <= '0;
        r_want_ar <= 1'b0;
        r_stat_done <= 1'b0;
        if (STAT_EN && r_stat_done) begin
          err_overrun <= 1'b0;
          err_underrun <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_al_spi_memory_slave.sv
// tb_al_spi_memory_slave: SPI master stimulus plus memory model with scoreboarded writes, reads and read addresses.
module tb_al_spi_memory_slave;
  localparam int HALF = 80;
  logic clk = 0, rst_n = 0, sclk = 0, csn = 1, mosi = 0;
  logic miso, oe, ovr, und;
  logic [31:0] rx;
  logic exp_ovr = 0, exp_und = 0;
  int n_cmp = 0, n_bad = 0;
  logic [37:0] exp_w[$];
  logic [5:0] exp_ar[$];
  logic [31:0] exp_rd[$];
  logic [31:0] tmem [64];
  int rd_lat = 2, cd = 0;
  logic pend = 0, hs_r;
  logic [5:0] paddr;
  al_spi_memory_slave_if mif();
  al_spi_memory_slave dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_csn(csn), .spi_mosi(mosi),
    .spi_miso(miso), .spi_miso_oe(oe), .mem(mif), .err_overrun(ovr), .err_underrun(und)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic spi_bits(input int n, input logic [31:0] tx, output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = tx[i];
      #HALF sclk = 1;
      r = {r[30:0], miso};
      #HALF sclk = 0;
    end
  endtask
  task automatic cs_low;
    @(negedge clk);
    csn = 0;
    #(2 * HALF);
  endtask
  task automatic cs_high;
    #(2 * HALF) csn = 1;
    #(6 * HALF);
  endtask
  task automatic set_wready(input logic v);
    @(posedge clk);
    #1 mif.m_mem_wready = v;
  endtask
  // Memory model: handshakes sampled at negedge, responses driven just after posedge
  always begin
    @(negedge clk);
    hs_r = mif.m_mem_rvalid & mif.m_mem_rready;
    if (mif.m_mem_arvalid && mif.m_mem_arready) begin
      check("ar_q", exp_ar.size() != 0, 1);
      if (exp_ar.size() != 0) check("araddr", mif.m_mem_araddr, exp_ar.pop_front());
      pend = 1;
      cd = rd_lat;
      paddr = mif.m_mem_araddr;
    end
    if (mif.m_mem_wvalid && mif.m_mem_wready) begin
      check("w_q", exp_w.size() != 0, 1);
      if (exp_w.size() != 0) check("write", {mif.m_mem_waddr, mif.m_mem_wdata}, exp_w.pop_front());
      tmem[mif.m_mem_waddr] = mif.m_mem_wdata;
    end
    @(posedge clk);
    #1;
    if (hs_r) mif.m_mem_rvalid = 0;
    if (pend) begin
      if (cd == 0) begin
        mif.m_mem_rvalid = 1;
        mif.m_mem_rdata = tmem[paddr];
        pend = 0;
      end else cd--;
    end
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 64; i++) tmem[i] = 32'h0;
    mif.m_mem_wready = 1;
    mif.m_mem_arready = 1;
    mif.m_mem_rvalid = 0;
    mif.m_mem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 1);
    check("rst_oe", oe, 0);
    check("rst_wvalid", mif.m_mem_wvalid, 0);
    check("rst_arvalid", mif.m_mem_arvalid, 0);
    check("rst_rready", mif.m_mem_rready, 0);
    check("rst_ovr", ovr, 0);
    check("rst_und", und, 0);
    rst_n = 1;
    repeat (4) @(negedge clk);
    // Two-word write at byte address 0x10 (word 4)
    exp_w.push_back({6'd4, 32'hDEADBEEF});
    exp_w.push_back({6'd5, 32'h01234567});
    cs_low;
    check("oe_sel", oe, 1);
    spi_bits(8, 32'h02, rx);
    spi_bits(8, 32'h10, rx);
    spi_bits(32, 32'hDEADBEEF, rx);
    spi_bits(32, 32'h01234567, rx);
    cs_high;
    check("wr_all", exp_w.size(), 0);
    check("wr_ovr", ovr, 0);
    check("wr_und", und, 0);
    // Read from word 62 with wrap, trailing prefetch included
    tmem[62] = 32'hA5A5A5A5;
    tmem[63] = 32'h5A5A5A5A;
    tmem[0] = 32'h11111111;
    tmem[1] = 32'h22222222;
    foreach (exp_ar[i]) exp_ar.delete(i);
    exp_ar.push_back(6'd62);
    exp_ar.push_back(6'd63);
    exp_ar.push_back(6'd0);
    exp_ar.push_back(6'd1);
    exp_ar.push_back(6'd2);
    exp_rd.push_back(32'hA5A5A5A5);
    exp_rd.push_back(32'h5A5A5A5A);
    exp_rd.push_back(32'h11111111);
    cs_low;
    spi_bits(8, 32'h03, rx);
    check("cmd_miso", rx[7:0], 8'hFF);
    spi_bits(8, 32'hF8, rx);
    spi_bits(8, 32'h0, rx);
    check("dummy_miso", rx[7:0], 8'hFF);
    for (int k = 0; k < 3; k++) begin
      spi_bits(32, 32'h0, rx);
      check("rd_word", rx, exp_rd.pop_front());
    end
    cs_high;
    check("rd_ar_all", exp_ar.size(), 0);
    check("rd_und", und, 0);
    // Overrun: three words while wready is held low
    set_wready(0);
    exp_w.push_back({6'd0, 32'h1});
    cs_low;
    spi_bits(8, 32'h02, rx);
    spi_bits(8, 32'h00, rx);
    spi_bits(32, 32'h1, rx);
    spi_bits(32, 32'h2, rx);
    spi_bits(32, 32'h3, rx);
    cs_high;
    check("ovr_hold", exp_w.size(), 1);
    check("ovr_wvalid", mif.m_mem_wvalid, 1);
    check("ovr_flag", ovr, 1);
    exp_ovr = 1;
    set_wready(1);
    repeat (10) @(negedge clk);
    check("ovr_written", exp_w.size(), 0);
    // Abort after 13 bits, then a clean transaction
    cs_low;
    spi_bits(8, 32'h02, rx);
    spi_bits(8, 32'h40, rx);
    spi_bits(13, 32'h1ABC, rx);
    cs_high;
    check("abort_wvalid", mif.m_mem_wvalid, 0);
    exp_w.push_back({6'd17, 32'hCAFEF00D});
    cs_low;
    spi_bits(8, 32'h02, rx);
    spi_bits(8, 32'h44, rx);
    spi_bits(32, 32'hCAFEF00D, rx);
    cs_high;
    check("after_abort", exp_w.size(), 0);
    // Underrun: first read data arrives after the dummy cycles
    rd_lat = 200;
    tmem[8] = 32'h13579BDF;
    tmem[9] = 32'h2468ACE0;
    tmem[10] = 32'h0F0F0F0F;
    exp_ar.push_back(6'd8);
    exp_ar.push_back(6'd9);
    exp_ar.push_back(6'd10);
    exp_ar.push_back(6'd11);
    exp_rd.push_back(32'hFFFFFFFF);
    exp_rd.push_back(32'h2468ACE0);
    cs_low;
    spi_bits(8, 32'h03, rx);
    spi_bits(8, 32'h20, rx);
    spi_bits(8, 32'h0, rx);
    for (int k = 0; k < 2; k++) begin
      spi_bits(32, 32'h0, rx);
      check("ur_word", rx, exp_rd.pop_front());
    end
    cs_high;
    check("ur_flag", und, 1);
    exp_und = 1;
    repeat (500) @(negedge clk);
    check("ur_ar_all", exp_ar.size(), 0);
    rd_lat = 2;
`ifdef AL_SPI_SLAVE_STATUS_EN
    cs_low;
    spi_bits(8, 32'h05, rx);
    spi_bits(8, 32'h0, rx);
    check("status", rx[7:0], {6'b0, exp_ovr, exp_und});
    cs_high;
    exp_ovr = 0;
    exp_und = 0;
    cs_low;
    spi_bits(8, 32'h05, rx);
    spi_bits(8, 32'h0, rx);
    check("status_clr", rx[7:0], {6'b0, exp_ovr, exp_und});
    cs_high;
`else
    cs_low;
    spi_bits(8, 32'h05, rx);
    spi_bits(8, 32'h0, rx);
    check("ignore", rx[7:0], 8'hFF);
    cs_high;
    check("ignore_und", und, exp_und);
`endif
    // Reset mid-read
    exp_ar.push_back(6'd0);
    exp_ar.push_back(6'd1);
    cs_low;
    spi_bits(8, 32'h03, rx);
    spi_bits(8, 32'h00, rx);
    spi_bits(8, 32'h0, rx);
    spi_bits(10, 32'h0, rx);
    check("mid_bits", rx[9:0], tmem[0][31:22]);
    check("mid_ar_all", exp_ar.size(), 0);
    rst_n = 0;
    #1;
    check("arst_miso", miso, 1);
    check("arst_oe", oe, 0);
    check("arst_arvalid", mif.m_mem_arvalid, 0);
    check("arst_rready", mif.m_mem_rready, 0);
    check("arst_wvalid", mif.m_mem_wvalid, 0);
    check("arst_ovr", ovr, 0);
    check("arst_und", und, 0);
    csn = 1;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
